ascensor_ctrl_n: RTL and testbench
==================================

// Module: ascensor_ctrl_n
// PURPOSE
//  Parametrised, clocked elevator controller for N_PISOS floors; successor of the fixed 4-floor TOP.
//  Latches hall/cabin requests, runs SCAN (keep direction while requests lie ahead), drives motor and doors.
//  Handles door timeout, reopen-on-obstruction and interlock fault. One instance per car, under board top.
// PARAMETERS
//  N_PISOS    4    number of floors (>=2); floor 0 = ground
//  W_PISO     $clog2(N_PISOS)  floor index width (derived, do not override)
//  T_PUERTA   50   cycles door stays fully open before closing (>=1)
// PORTS
//  clk             in   1        system clock, rising edge
//  rst             in   1        asynchronous, active-high reset
//  btn_subir       in   N_PISOS  hall up buttons, level; bit N_PISOS-1 ignored
//  btn_bajar       in   N_PISOS  hall down buttons, level; bit 0 ignored
//  btn_cabina      in   N_PISOS  cabin floor buttons, level
//  btn_abrir       in   1        cabin door-open button
//  btn_cerrar      in   1        cabin door-close button
//  puerta_abierta  in   1        limit sensor: door fully open
//  puerta_cerrada  in   1        limit sensor: door fully closed
//  sensor_puertas  in   1        obstruction between doors
//  cambio_piso     in   1        one-cycle pulse when car reaches next floor
//  luz_subir/luz_bajar/luz_cabina out N_PISOS  pending-request lamps (= request regs)
//  piso            out  W_PISO   current floor (display)
//  dir             out  1        1 up, 0 down
//  motor           out  2        00 stop, 01 up, 10 down (11 never)
//  puertas         out  2        00 hold, 01 open, 10 close (11 never)
//  aviso           out  N_PISOS  one-cycle arrival chime, one-hot at piso
//  falla           out  1        sticky fault; cleared only by rst
// BEHAVIOUR
//  Reset: all request regs 0, piso=0, dir=1, motor=00, puertas=00, aviso=0, falla=0, state REPOSO.
//  All outputs registered. Button high at edge t -> lamp high after t+1 (set has 1-cycle latency).
//  Request bit cleared on service (entry to ABRIENDO at floor f): cabina[f], plus hall bit of dir;
//   if no requests beyond f in dir, also opposite hall bit and dir flips. Clear wins over same-cycle set.
//  States: REPOSO, MOVIENDO, ABRIENDO, ABIERTA, CERRANDO.
//  REPOSO: request at piso -> ABRIENDO; else requests ahead in dir -> MOVIENDO;
//   else requests behind -> flip dir, MOVIENDO next cycle; none -> stay. Up-priority when both at reset dir.
//  MOVIENDO: motor=01/10 per dir. On cambio_piso: piso +/-1; stop if new floor has cabina, hall in dir,
//   or no requests beyond (then any hall). Stop -> motor=00, aviso[piso]=1 one cycle, ABRIENDO.
//  ABRIENDO: puertas=01 until puerta_abierta -> ABIERTA, timer loaded T_PUERTA-1.
//  ABIERTA: puertas=00; timer decrements; btn_abrir or sensor_puertas reloads; btn_cerrar forces 0;
//   timer==0 and !sensor_puertas -> CERRANDO.
//  CERRANDO: puertas=10; sensor_puertas or btn_abrir -> ABRIENDO (no re-clear, no chime);
//   puerta_cerrada -> REPOSO. Buttons for piso pressed while door open/closing are cleared immediately.
//  Interlock: motor!=00 only if puerta_cerrada. puerta_cerrada low in MOVIENDO -> motor=00, falla=1, REPOSO,
//   no further motion until rst. cambio_piso at floor 0 going down or N_PISOS-1 going up -> falla=1,
//   piso unchanged. cambio_piso outside MOVIENDO ignored.
//  rst mid-travel: immediate motor=00, puertas=00 asynchronously; piso returns 0 (recalibration by upper level).
// STRUCTURE
//  Package ascensor_pkg: estado_t enum, MOTOR_*/PUERTA_* 2-bit codes, helper functions
//   hay_arriba(req,piso)/hay_abajo(req,piso).
//  Sub-module registro_solicitudes_n: request regs with set/clear masks and lamp outputs.
//  Top holds FSM, floor counter, door timer.
// TESTING (N_PISOS=4, T_PUERTA=5)
//  Reset, idle, cabin btn 2 -> motor=01, 2 cambio_piso -> piso=2, aviso=0100, puertas=01, luz_cabina[2]=0.
//  At floor 2 dir up, hall bajar[1]+cabina[3] -> serves 3 first, flips dir, then 1; lamps clear in order.
//  ABIERTA, sensor_puertas high 20 cycles -> puertas stays 00; drop -> close after 5 cycles; obstruct in
//   CERRANDO -> puertas=01 again.
//  MOVIENDO, puerta_cerrada drops -> motor=00 next cycle, falla=1, new requests never move car.
//  cambio_piso at piso=3 moving up -> falla=1, piso stays 3; rst mid-move -> all outputs reset values.
//  btn_cabina[piso] pressed during ABIERTA -> lamp never latches; timer reload via btn_abrir.

Source files
------------

// File: rtl/ascensor_pkg.sv
// Shared definitions for the elevator controller: state codes, motor/door codes
// and the request-scan helpers used by the SCAN policy.
package ascensor_pkg;

    localparam int MAX_PISOS = 64;

    typedef logic [2:0] estado_t;

    localparam estado_t REPOSO   = 3'd0;
    localparam estado_t MOVIENDO = 3'd1;
    localparam estado_t ABRIENDO = 3'd2;
    localparam estado_t ABIERTA  = 3'd3;
    localparam estado_t CERRANDO = 3'd4;

    localparam logic [1:0] MOTOR_STOP   = 2'b00;
    localparam logic [1:0] MOTOR_SUBE   = 2'b01;
    localparam logic [1:0] MOTOR_BAJA   = 2'b10;

    localparam logic [1:0] PUERTA_HOLD  = 2'b00;
    localparam logic [1:0] PUERTA_ABRIR = 2'b01;
    localparam logic [1:0] PUERTA_CERRAR = 2'b10;

    // Any pending request strictly above floor p.
    function automatic logic hay_arriba(input logic [MAX_PISOS-1:0] req, input int p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_PISOS; i++)
            if (i > p && req[i]) r = 1'b1;
        return r;
    endfunction

    // Any pending request strictly below floor p.
    function automatic logic hay_abajo(input logic [MAX_PISOS-1:0] req, input int p);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_PISOS; i++)
            if (i < p && req[i]) r = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/registro_solicitudes_n.sv
// Pending-request registers (hall up, hall down, cabin). Clear beats a same-cycle set;
// the registers themselves drive the lamps.
module registro_solicitudes_n #(
    parameter int N_PISOS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PISOS-1:0] set_subir_i,
    input  logic [N_PISOS-1:0] set_bajar_i,
    input  logic [N_PISOS-1:0] set_cabina_i,
    input  logic [N_PISOS-1:0] clr_subir_i,
    input  logic [N_PISOS-1:0] clr_bajar_i,
    input  logic [N_PISOS-1:0] clr_cabina_i,
    output logic [N_PISOS-1:0] luz_subir_o,
    output logic [N_PISOS-1:0] luz_bajar_o,
    output logic [N_PISOS-1:0] luz_cabina_o
);

    // No up call from the top floor, no down call from the ground floor.
    localparam logic [N_PISOS-1:0] MASK_SUBIR = {1'b0, {(N_PISOS-1){1'b1}}};
    localparam logic [N_PISOS-1:0] MASK_BAJAR = {{(N_PISOS-1){1'b1}}, 1'b0};

    logic [N_PISOS-1:0] subir_q, subir_d;
    logic [N_PISOS-1:0] bajar_q, bajar_d;
    logic [N_PISOS-1:0] cabina_q, cabina_d;

    always_comb begin
        subir_d  = (subir_q  | (set_subir_i & MASK_SUBIR)) & ~clr_subir_i;
        bajar_d  = (bajar_q  | (set_bajar_i & MASK_BAJAR)) & ~clr_bajar_i;
        cabina_d = (cabina_q | set_cabina_i)               & ~clr_cabina_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            subir_q  <= '0;
            bajar_q  <= '0;
            cabina_q <= '0;
        end else begin
            subir_q  <= subir_d;
            bajar_q  <= bajar_d;
            cabina_q <= cabina_d;
        end
    end

    assign luz_subir_o  = subir_q;
    assign luz_bajar_o  = bajar_q;
    assign luz_cabina_o = cabina_q;

endmodule

// File: rtl/ascensor_ctrl_n.sv
// One-car elevator controller: SCAN scheduling, floor tracking, door sequencing with
// dwell timer, and a sticky interlock fault that freezes the car until reset.
module ascensor_ctrl_n
    import ascensor_pkg::*;
#(
    parameter int N_PISOS  = 4,
    parameter int W_PISO   = $clog2(N_PISOS),
    parameter int T_PUERTA = 50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PISOS-1:0] btn_subir,
    input  logic [N_PISOS-1:0] btn_bajar,
    input  logic [N_PISOS-1:0] btn_cabina,
    input  logic               btn_abrir,
    input  logic               btn_cerrar,
    input  logic               puerta_abierta,
    input  logic               puerta_cerrada,
    input  logic               sensor_puertas,
    input  logic               cambio_piso,
    output logic [N_PISOS-1:0] luz_subir,
    output logic [N_PISOS-1:0] luz_bajar,
    output logic [N_PISOS-1:0] luz_cabina,
    output logic [W_PISO-1:0]  piso,
    output logic               dir,
    output logic [1:0]         motor,
    output logic [1:0]         puertas,
    output logic [N_PISOS-1:0] aviso,
    output logic               falla
);

    localparam int W_T = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;
    localparam logic [W_T-1:0] T_CARGA = W_T'(T_PUERTA - 1);

    estado_t            estado_q, estado_d;
    logic [W_PISO-1:0]  piso_q, piso_d;
    logic               dir_q, dir_d;
    logic [1:0]         motor_q, motor_d;
    logic [1:0]         puertas_q, puertas_d;
    logic [N_PISOS-1:0] aviso_q, aviso_d;
    logic               falla_q, falla_d;
    logic [W_T-1:0]     timer_q, timer_d;

    logic [N_PISOS-1:0] subir_q, bajar_q, cabina_q;
    logic [N_PISOS-1:0] clr_subir, clr_bajar, clr_cabina;
    logic [MAX_PISOS-1:0] req_ext;

    registro_solicitudes_n #(.N_PISOS(N_PISOS)) u_req (
        .clk         (clk),
        .rst         (rst),
        .set_subir_i (btn_subir),
        .set_bajar_i (btn_bajar),
        .set_cabina_i(btn_cabina),
        .clr_subir_i (clr_subir),
        .clr_bajar_i (clr_bajar),
        .clr_cabina_i(clr_cabina),
        .luz_subir_o (subir_q),
        .luz_bajar_o (bajar_q),
        .luz_cabina_o(cabina_q)
    );

    always_comb begin
        req_ext = '0;
        req_ext[N_PISOS-1:0] = subir_q | bajar_q | cabina_q;
    end

    // Scan view from the current floor and from the floor the car is about to reach.
    logic [W_PISO-1:0] piso_sig;
    logic adel_aqui, atras_aqui, adel_sig, en_limite;
    logic cab_aqui, hall_dir_aqui, hall_opp_aqui, cab_sig, hall_dir_sig;

    always_comb begin
        piso_sig      = dir_q ? piso_q + 1'b1 : piso_q - 1'b1;
        en_limite     = dir_q ? (piso_q == W_PISO'(N_PISOS - 1)) : (piso_q == '0);
        adel_aqui     = dir_q ? hay_arriba(req_ext, int'(piso_q)) : hay_abajo(req_ext, int'(piso_q));
        atras_aqui    = dir_q ? hay_abajo(req_ext, int'(piso_q)) : hay_arriba(req_ext, int'(piso_q));
        adel_sig      = dir_q ? hay_arriba(req_ext, int'(piso_sig)) : hay_abajo(req_ext, int'(piso_sig));
        cab_aqui      = cabina_q[piso_q];
        hall_dir_aqui = dir_q ? subir_q[piso_q] : bajar_q[piso_q];
        hall_opp_aqui = dir_q ? bajar_q[piso_q] : subir_q[piso_q];
        cab_sig       = cabina_q[piso_sig];
        hall_dir_sig  = dir_q ? subir_q[piso_sig] : bajar_q[piso_sig];
    end

    logic              servir, adel_srv;
    logic [W_PISO-1:0] piso_srv;

    always_comb begin
        estado_d   = estado_q;
        piso_d     = piso_q;
        dir_d      = dir_q;
        motor_d    = motor_q;
        puertas_d  = puertas_q;
        aviso_d    = '0;
        falla_d    = falla_q;
        timer_d    = timer_q;
        clr_subir  = '0;
        clr_bajar  = '0;
        clr_cabina = '0;
        servir     = 1'b0;
        adel_srv   = 1'b0;
        piso_srv   = piso_q;

        case (estado_q)
            REPOSO: if (!falla_q) begin
                if (cab_aqui || hall_dir_aqui || (!adel_aqui && hall_opp_aqui)) begin
                    estado_d  = ABRIENDO;
                    puertas_d = PUERTA_ABRIR;
                    servir    = 1'b1;
                    adel_srv  = adel_aqui;
                end else if (adel_aqui) begin
                    if (puerta_cerrada) begin
                        estado_d = MOVIENDO;
                        motor_d  = dir_q ? MOTOR_SUBE : MOTOR_BAJA;
                    end
                end else if (atras_aqui) begin
                    dir_d = ~dir_q;
                end
            end
            MOVIENDO: begin
                if (!puerta_cerrada || (cambio_piso && en_limite)) begin
                    motor_d  = MOTOR_STOP;
                    falla_d  = 1'b1;
                    estado_d = REPOSO;
                end else if (cambio_piso) begin
                    piso_d = piso_sig;
                    if (cab_sig || hall_dir_sig || !adel_sig) begin
                        motor_d           = MOTOR_STOP;
                        aviso_d[piso_sig] = 1'b1;
                        estado_d          = ABRIENDO;
                        puertas_d         = PUERTA_ABRIR;
                        servir            = 1'b1;
                        piso_srv          = piso_sig;
                        adel_srv          = adel_sig;
                    end
                end
            end
            ABRIENDO: if (puerta_abierta) begin
                estado_d  = ABIERTA;
                puertas_d = PUERTA_HOLD;
                timer_d   = T_CARGA;
            end
            ABIERTA: begin
                if (btn_abrir || sensor_puertas) timer_d = T_CARGA;
                else if (btn_cerrar)             timer_d = '0;
                else if (timer_q != '0)          timer_d = timer_q - 1'b1;
                if (timer_q == '0 && !sensor_puertas && !btn_abrir) begin
                    estado_d  = CERRANDO;
                    puertas_d = PUERTA_CERRAR;
                end
            end
            CERRANDO: begin
                if (sensor_puertas || btn_abrir) begin
                    estado_d  = ABRIENDO;
                    puertas_d = PUERTA_ABRIR;
                end else if (puerta_cerrada) begin
                    estado_d  = REPOSO;
                    puertas_d = PUERTA_HOLD;
                end
            end
            default: begin
                estado_d  = REPOSO;
                motor_d   = MOTOR_STOP;
                puertas_d = PUERTA_HOLD;
            end
        endcase

        // Service: cabin and hall-in-direction; at the end of a sweep also the opposite call, and turn.
        if (servir) begin
            clr_cabina[piso_srv] = 1'b1;
            if (dir_q) clr_subir[piso_srv] = 1'b1;
            else       clr_bajar[piso_srv] = 1'b1;
            if (!adel_srv) begin
                if (dir_q) clr_bajar[piso_srv] = 1'b1;
                else       clr_subir[piso_srv] = 1'b1;
                dir_d = ~dir_q;
            end
        end

        // Calls for this floor while the door is in motion or open are already being served.
        if (estado_q == ABRIENDO || estado_q == ABIERTA || estado_q == CERRANDO) begin
            clr_cabina[piso_q] = 1'b1;
            if (dir_q) clr_subir[piso_q] = 1'b1;
            else       clr_bajar[piso_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= REPOSO;
            piso_q    <= '0;
            dir_q     <= 1'b1;
            motor_q   <= MOTOR_STOP;
            puertas_q <= PUERTA_HOLD;
            aviso_q   <= '0;
            falla_q   <= 1'b0;
            timer_q   <= '0;
        end else begin
            estado_q  <= estado_d;
            piso_q    <= piso_d;
            dir_q     <= dir_d;
            motor_q   <= motor_d;
            puertas_q <= puertas_d;
            aviso_q   <= aviso_d;
            falla_q   <= falla_d;
            timer_q   <= timer_d;
        end
    end

    assign luz_subir  = subir_q;
    assign luz_bajar  = bajar_q;
    assign luz_cabina = cabina_q;
    assign piso       = piso_q;
    assign dir        = dir_q;
    assign motor      = motor_q;
    assign puertas    = puertas_q;
    assign aviso      = aviso_q;
    assign falla      = falla_q;

endmodule

// File: tb/tb_ascensor_ctrl_n.sv
// Directed bench for a 4-floor car with a 5-cycle door dwell; arrival chimes are
// checked against a queue of expected arrivals, other behaviour by direct checks.
module tb_ascensor_ctrl_n;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] btn_subir = '0, btn_bajar = '0, btn_cabina = '0;
    logic btn_abrir = 1'b0, btn_cerrar = 1'b0, sensor_puertas = 1'b0, cambio_piso = 1'b0;
    logic puerta_abierta, puerta_cerrada;
    logic [N-1:0] luz_subir, luz_bajar, luz_cabina, aviso;
    logic [1:0] piso, motor, puertas;
    logic dir, falla;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ascensor_ctrl_n #(.N_PISOS(N), .T_PUERTA(5)) dut (
        .clk(clk), .rst(rst),
        .btn_subir(btn_subir), .btn_bajar(btn_bajar), .btn_cabina(btn_cabina),
        .btn_abrir(btn_abrir), .btn_cerrar(btn_cerrar),
        .puerta_abierta(puerta_abierta), .puerta_cerrada(puerta_cerrada),
        .sensor_puertas(sensor_puertas), .cambio_piso(cambio_piso),
        .luz_subir(luz_subir), .luz_bajar(luz_bajar), .luz_cabina(luz_cabina),
        .piso(piso), .dir(dir), .motor(motor), .puertas(puertas),
        .aviso(aviso), .falla(falla)
    );

    // Door plant: three cycles between fully closed and fully open.
    int   pos = 0;
    logic break_cerr = 1'b0;
    assign puerta_cerrada = (pos == 0) && !break_cerr;
    assign puerta_abierta = (pos == 3);

    initial forever begin
        @(posedge clk);
        #1;
        if (puertas == 2'b01 && pos < 3) pos++;
        else if (puertas == 2'b10 && pos > 0) pos--;
    end

    typedef struct packed {
        logic [1:0]   piso;
        logic         dir;
        logic [1:0]   motor;
        logic [1:0]   puertas;
        logic [N-1:0] aviso;
        logic [N-1:0] cab;
        logic [N-1:0] baj;
    } ev_t;

    ev_t sb[$];

    function automatic ev_t mk(input logic [1:0] p, input logic d, input logic [3:0] av,
                               input logic [3:0] c, input logic [3:0] b);
        ev_t e;
        e.piso = p; e.dir = d; e.motor = 2'b00; e.puertas = 2'b01;
        e.aviso = av; e.cab = c; e.baj = b;
        return e;
    endfunction

    // Monitor: every chime must match the next expected arrival.
    initial forever begin
        @(negedge clk);
        if (!rst && aviso != '0) begin
            ev_t act, exp;
            act.piso = piso; act.dir = dir; act.motor = motor; act.puertas = puertas;
            act.aviso = aviso; act.cab = luz_cabina; act.baj = luz_bajar;
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL arrival_unexpected: got %h, no arrival expected", act);
            end else begin
                exp = sb.pop_front();
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL arrival: got %h expected %h", act, exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic cond(input int sel, input logic [1:0] v);
        case (sel)
            0:       return puertas == v;
            1:       return motor == v;
            default: return puerta_abierta;
        endcase
    endfunction

    // Counts negedges until the condition holds; an expired budget is a failure.
    task automatic esperar(input string nm, input int sel, input logic [1:0] v,
                           input int budget, output int n);
        n = 0;
        while (!cond(sel, v) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cond(sel, v)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles, condition never reached", nm, n);
        end
    endtask

    task automatic pulso_piso();
        @(negedge clk) cambio_piso = 1'b1;
        @(negedge clk) cambio_piso = 1'b0;
    endtask

    task automatic pulsar(input logic [3:0] cab, input logic [3:0] baj);
        @(negedge clk) begin btn_cabina = cab; btn_bajar = baj; end
        @(negedge clk) begin btn_cabina = '0;  btn_bajar = '0;  end
    endtask

    task automatic ciclo_puerta(input string nm);
        int n;
        esperar({nm, "_close"}, 0, 2'b10, 60, n);
        esperar({nm, "_closed"}, 0, 2'b00, 20, n);
    endtask

    initial begin
        int n;
        logic bad_p, bad_l;
        repeat (3) @(negedge clk);
        chk("rst_piso", piso, 0);
        chk("rst_dir", dir, 1);
        chk("rst_motor", motor, 0);
        chk("rst_puertas", puertas, 0);
        chk("rst_aviso", aviso, 0);
        chk("rst_falla", falla, 0);
        chk("rst_lamps", {luz_subir, luz_bajar, luz_cabina}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_motor", motor, 0);

        // Cabin call to 2; further calls arrive while passing floor 1.
        @(negedge clk) btn_cabina = 4'b0100;
        @(negedge clk) btn_cabina = '0;
        chk("lamp_latch", luz_cabina, 4'b0100);
        @(negedge clk);
        chk("start_up", motor, 2'b01);
        pulso_piso();
        chk("floor1_piso", piso, 1);
        chk("floor1_moving", motor, 2'b01);
        pulsar(4'b1000, 4'b0010);
        sb.push_back(mk(2'd2, 1'b1, 4'b0100, 4'b1000, 4'b0010));
        pulso_piso();
        ciclo_puerta("door2");
        esperar("leave2_up", 1, 2'b01, 10, n);
        sb.push_back(mk(2'd3, 1'b0, 4'b1000, 4'b0000, 4'b0010));
        pulso_piso();
        ciclo_puerta("door3");
        esperar("leave3_down", 1, 2'b10, 10, n);
        chk("dir_after_top", dir, 0);
        pulso_piso();
        chk("pass2_piso", piso, 2);
        sb.push_back(mk(2'd1, 1'b1, 4'b0010, 4'b0000, 4'b0000));
        pulso_piso();

        // Obstruction while open at floor 1, with the cabin button for this floor pressed.
        esperar("open1", 2, 2'b00, 10, n);
        @(negedge clk);
        bad_p = 1'b0; bad_l = 1'b0;
        sensor_puertas = 1'b1;
        btn_cabina     = 4'b0010;
        repeat (20) begin
            @(negedge clk);
            if (puertas != 2'b00) bad_p = 1'b1;
            if (luz_cabina[1])    bad_l = 1'b1;
        end
        sensor_puertas = 1'b0;
        btn_cabina     = '0;
        chk("obstr_hold", bad_p, 0);
        chk("cab_here_no_lamp", bad_l, 0);
        esperar("close_after_drop", 0, 2'b10, 20, n);
        chk("close_after_drop", n, 5);
        sensor_puertas = 1'b1;
        @(negedge clk);
        sensor_puertas = 1'b0;
        chk("reopen", puertas, 2'b01);
        esperar("reopen_full", 2, 2'b00, 10, n);
        btn_abrir = 1'b1;
        repeat (3) @(negedge clk);
        btn_abrir = 1'b0;
        esperar("reload_abrir", 0, 2'b10, 20, n);
        chk("reload_abrir", n, 5);
        esperar("door1_closed", 0, 2'b00, 20, n);

        // Interlock: door-closed lost while moving.
        pulsar(4'b1000, 4'b0000);
        esperar("start_interlock", 1, 2'b01, 10, n);
        break_cerr = 1'b1;
        @(negedge clk);
        break_cerr = 1'b0;
        chk("interlock_motor", motor, 0);
        chk("interlock_falla", falla, 1);
        pulsar(4'b0001, 4'b0000);
        pulso_piso();
        repeat (10) @(negedge clk);
        chk("fault_no_move", motor, 0);
        chk("fault_piso", piso, 1);
        chk("fault_sticky", falla, 1);

        // Reset clears the fault; then an asynchronous reset mid-travel.
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst_clears_falla", falla, 0);
        pulsar(4'b1000, 4'b0000);
        esperar("start_again", 1, 2'b01, 10, n);
        pulso_piso();
        chk("mid_piso", piso, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_motor", motor, 0);
        chk("async_puertas", puertas, 0);
        chk("async_piso", piso, 0);
        chk("async_dir", dir, 1);
        chk("async_lamps", luz_cabina, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
